// File: rtl/renkon_output_writer.sv
// Renkon output writer: drains per-core mux results into output feature-map memory.
// Optional macro RENKON_OUTPUT_RELU_EN applies ReLU at the write stage.
module renkon_output_writer #(
    parameter int CORE    = 8,
    parameter int CORELOG = 3,
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [AWIDTH-1:0]        base_addr,
    input  logic [AWIDTH-1:0]        stride,
    input  logic [CORELOG:0]         n_active,
    input  logic                     start,
    output logic                     busy,
    output logic                     round_done,
    output logic [CORELOG:0]         output_re,
    input  logic signed [DWIDTH-1:0] out_data,
    output logic                     mem_we,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic signed [DWIDTH-1:0] mem_wdata
);

    localparam logic [CORELOG:0] CORE_N = (CORELOG+1)'(CORE);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_t;

    state_t             state;
    logic [CORELOG-1:0] core_cnt;
    logic [CORELOG:0]   n_q;
    logic [CORELOG:0]   n_eff;
    logic [CORELOG-1:0] last_c;
    logic [AWIDTH-1:0]  base_q;
    logic [AWIDTH-1:0]  stride_q;
    logic [AWIDTH-1:0]  pix_cnt;
    logic [AWIDTH-1:0]  addr_cur;
    logic [AWIDTH-1:0]  s1_addr;
    logic               s1_valid;
    logic               flush_cnt;
    logic signed [DWIDTH-1:0] wdata_next;

    // A zero or oversized core count means "all cores".
    always_comb begin
        n_eff = n_q;
        if (n_q == '0 || n_q > CORE_N) begin
            n_eff = CORE_N;
        end
        last_c = CORELOG'(n_eff - 1'b1);
    end

`ifdef RENKON_OUTPUT_RELU_EN
    assign wdata_next = out_data[DWIDTH-1] ? '0 : out_data;
`else
    assign wdata_next = out_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            core_cnt   <= '0;
            n_q        <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            pix_cnt    <= '0;
            addr_cur   <= '0;
            s1_addr    <= '0;
            s1_valid   <= 1'b0;
            flush_cnt  <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            output_re  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (init) begin
            state      <= IDLE;
            core_cnt   <= '0;
            n_q        <= n_active;
            base_q     <= base_addr;
            stride_q   <= stride;
            pix_cnt    <= '0;
            s1_valid   <= 1'b0;
            flush_cnt  <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            output_re  <= '0;
            mem_we     <= 1'b0;
        end else begin
            // Stage 1 tags the address while the mux registers its data;
            // stage 2 pairs that address with out_data.
            mem_we   <= s1_valid;
            if (s1_valid) begin
                mem_addr  <= s1_addr;
                mem_wdata <= wdata_next;
            end
            s1_valid   <= (state == DRAIN);
            if (state == DRAIN) begin
                s1_addr <= addr_cur;
            end
            round_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAIN;
                        core_cnt  <= '0;
                        addr_cur  <= base_q + pix_cnt;
                        output_re <= (CORELOG+1)'(1);
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (core_cnt == last_c) begin
                        state     <= FLUSH;
                        output_re <= '0;
                        flush_cnt <= 1'b0;
                    end else begin
                        core_cnt  <= core_cnt + 1'b1;
                        addr_cur  <= addr_cur + stride_q;
                        output_re <= output_re + 1'b1;
                    end
                end
                FLUSH: begin
                    if (!flush_cnt) begin
                        flush_cnt  <= 1'b1;
                        round_done <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pix_cnt   <= pix_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_renkon_output_writer.sv
// Randomized bench for renkon_output_writer against a round-level reference model.
// Honours RENKON_OUTPUT_RELU_EN for the expected write data.
module tb_renkon_output_writer;

    localparam int CORE    = 8;
    localparam int CORELOG = 3;
    localparam int DWIDTH  = 16;
    localparam int AWIDTH  = 12;
    localparam int AMASK   = (1 << AWIDTH) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     init;
    logic                     start;
    logic [AWIDTH-1:0]        base_addr;
    logic [AWIDTH-1:0]        stride;
    logic [CORELOG:0]         n_active;
    logic                     busy;
    logic                     round_done;
    logic [CORELOG:0]         output_re;
    logic signed [DWIDTH-1:0] out_data;
    logic                     mem_we;
    logic [AWIDTH-1:0]        mem_addr;
    logic signed [DWIDTH-1:0] mem_wdata;

    int vectors     = 0;
    int miscompares = 0;

    logic signed [DWIDTH-1:0] core_val [CORE];

    int m_base;
    int m_stride;
    int m_n;
    int m_pix;

    renkon_output_writer #(
        .CORE(CORE), .CORELOG(CORELOG), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)
    ) dut (
        .clk(clk), .rst(rst), .init(init),
        .base_addr(base_addr), .stride(stride), .n_active(n_active),
        .start(start), .busy(busy), .round_done(round_done),
        .output_re(output_re), .out_data(out_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Registered output mux: select 0 gives zero, k gives core k-1.
    always @(posedge clk) begin
        if (output_re == '0 || int'(output_re) > CORE)
            out_data <= '0;
        else
            out_data <= core_val[int'(output_re) - 1];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [DWIDTH-1:0] exp_data(
        input logic signed [DWIDTH-1:0] v);
`ifdef RENKON_OUTPUT_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int clamp_n(input int n);
        return (n == 0 || n > CORE) ? CORE : n;
    endfunction

    task automatic do_init(input int b, input int s, input int n);
        @(negedge clk);
        init      = 1'b1;
        base_addr = AWIDTH'(b);
        stride    = AWIDTH'(s);
        n_active  = (CORELOG+1)'(n);
        @(negedge clk);
        init     = 1'b0;
        m_base   = b & AMASK;
        m_stride = s & AMASK;
        m_n      = clamp_n(n);
        m_pix    = 0;
        check("init_busy", 64'(busy), 64'(0));
    endtask

    // Cycle i counts from the first cycle after the accepted start.
    task automatic run_round(input bit rnd, input int spur);
        int exp_addr;
        bit exp_we;
        if (rnd)
            for (int k = 0; k < CORE; k++) core_val[k] = DWIDTH'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= m_n + 3; i++) begin
            exp_we = (i >= 3 && i <= m_n + 2);
            check("re", 64'(output_re), 64'((i <= m_n) ? i : 0));
            check("busy", 64'(busy), 64'(i <= m_n + 2));
            check("done", 64'(round_done), 64'(i == m_n + 2));
            check("we", 64'(mem_we), 64'(exp_we));
            if (exp_we && mem_we) begin
                exp_addr = (m_base + (i - 3) * m_stride + m_pix) & AMASK;
                check("addr", 64'(mem_addr), 64'(exp_addr));
                check("data", 64'(mem_wdata), 64'(exp_data(core_val[i - 3])));
            end
            start = (i == spur);
            @(negedge clk);
        end
        start = 1'b0;
        m_pix = (m_pix + 1) & AMASK;
    endtask

    task automatic abort_round(input int b, input int s, input int n);
        for (int k = 0; k < CORE; k++) core_val[k] = DWIDTH'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("abort_re", 64'(output_re), 64'(i));
            if (i < 3) @(negedge clk);
        end
        init      = 1'b1;
        base_addr = AWIDTH'(b);
        stride    = AWIDTH'(s);
        n_active  = (CORELOG+1)'(n);
        @(negedge clk);
        init     = 1'b0;
        m_base   = b & AMASK;
        m_stride = s & AMASK;
        m_n      = clamp_n(n);
        m_pix    = 0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_re0", 64'(output_re), 64'(0));
        for (int i = 0; i < 5; i++) begin
            check("abort_we", 64'(mem_we), 64'(0));
            check("abort_done", 64'(round_done), 64'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < CORE; k++) core_val[k] = '0;
        rst = 1'b1; init = 1'b0; start = 1'b0;
        base_addr = '0; stride = '0; n_active = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            check("rst_idle", {29'b0, busy, round_done, mem_we, output_re,
                               mem_addr, mem_wdata}, 64'(0));
            @(negedge clk);
        end

        do_init('h100, 'h40, 4);
        core_val[0] = 11; core_val[1] = 22; core_val[2] = 33; core_val[3] = 44;
        run_round(1'b0, 0);

        do_init('hFFE, 1, 2);
        repeat (3) run_round(1'b1, 0);

        do_init('h200, 3, 0);
        run_round(1'b1, 0);
        do_init('h010, 'h100, 9);
        run_round(1'b1, 0);

        do_init('h300, 5, 5);
        run_round(1'b1, 2);
        run_round(1'b1, 4);

        do_init('h400, 'h10, 6);
        abort_round('h500, 'h20, 3);
        run_round(1'b1, 0);

        do_init(0, 1, 2);
        core_val[0] = -5; core_val[1] = 7;
        run_round(1'b0, 0);

        // init and start together: start is dropped.
        init = 1'b1; start = 1'b1;
        base_addr = 'h600; stride = 'h8; n_active = 3;
        @(negedge clk);
        init = 1'b0; start = 1'b0;
        m_base = 'h600; m_stride = 'h8; m_n = 3; m_pix = 0;
        for (int i = 0; i < 4; i++) begin
            check("init_start_busy", 64'(busy), 64'(0));
            check("init_start_we", 64'(mem_we), 64'(0));
            @(negedge clk);
        end
        run_round(1'b1, 0);

        // Asynchronous reset in the middle of a round.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", {29'b0, busy, round_done, mem_we, output_re,
                               mem_addr, mem_wdata}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_base = 0; m_stride = 0; m_n = CORE; m_pix = 0;
        for (int i = 0; i < 6; i++) begin
            check("post_rst_we", 64'(mem_we), 64'(0));
            check("post_rst_busy", 64'(busy), 64'(0));
            @(negedge clk);
        end
        run_round(1'b1, 0);

        for (int r = 0; r < 20; r++) begin
            do_init(int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
                    int'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 3))
                run_round(1'b1, ($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
